// File: rtl/sar_ctrl_6b.sv
// Successive-approximation controller for a binary-weighted CDAC: sample phase,
// then one bit decision per clock, MSB first, with registered outputs throughout.
module sar_ctrl_6b #(
    parameter int NBIT          = 6,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic            CMP,
    output logic            SAMPLE,
    output logic [NBIT-1:0] CB,
    output logic [NBIT-1:0] DOUT,
    output logic            DONE,
    output logic            BUSY
);

    localparam int IW = (NBIT > 1) ? $clog2(NBIT) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SAMP = 2'd1;
    localparam logic [1:0] ST_CONV = 2'd2;

    localparam logic [3:0]      CNT_LOAD = 4'(SAMPLE_CYCLES - 1);
    localparam logic [IW-1:0]   IDX_MSB  = IW'(NBIT - 1);
    localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
    localparam logic [NBIT-1:0] MSB_CODE = {1'b1, {(NBIT-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            sample_q, sample_d;
    logic [NBIT-1:0] cb_q, cb_d;
    logic [NBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [NBIT-1:0] trial_s;

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sample_d = sample_q;
        cb_d     = cb_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        trial_s  = cb_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d  = ST_SAMP;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                    cb_d     = '0;
                    cnt_d    = CNT_LOAD;
                    idx_d    = '0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_SAMP: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_CONV;
                    sample_d = 1'b0;
                    cb_d     = MSB_CODE;
                    idx_d    = IDX_MSB;
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                end
            end

            ST_CONV: begin
                // A high comparator means the trial bit overshoots and is dropped.
                if (CMP) begin
                    trial_s[idx_q] = 1'b0;
                end else begin
                    trial_s[idx_q] = cb_q[idx_q];
                end
                if (idx_q != '0) begin
                    trial_s[idx_q - IDX_ONE] = 1'b1;
                    idx_d  = idx_q - IDX_ONE;
                    cb_d   = trial_s;
                end else begin
                    cb_d    = trial_s;
                    dout_d  = trial_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                sample_d = 1'b0;
                busy_d   = 1'b0;
                cnt_d    = 4'd0;
                idx_d    = '0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            sample_q <= 1'b0;
            cb_q     <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sample_q <= sample_d;
            cb_q     <= cb_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign SAMPLE = sample_q;
    assign CB     = cb_q;
    assign DOUT   = dout_q;
    assign DONE   = done_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_sar_ctrl_6b.sv
// Self-checking bench for sar_ctrl_6b: an ideal comparator against a target,
// and a binary-search reference model for the trial codes and final result.
module tb_sar_ctrl_6b;

    localparam int NB = 6;
    localparam int SC = 2;

    logic          CLK;
    logic          RST_N;
    logic          START;
    logic          CMP;
    logic          SAMPLE;
    logic [NB-1:0] CB;
    logic [NB-1:0] DOUT;
    logic          DONE;
    logic          BUSY;

    logic [NB-1:0] target;
    logic [NB-1:0] model_dout;
    int            n_checks;
    int            n_fail;

    sar_ctrl_6b #(.NBIT(NB), .SAMPLE_CYCLES(SC)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .CMP    (CMP),
        .SAMPLE (SAMPLE),
        .CB     (CB),
        .DOUT   (DOUT),
        .DONE   (DONE),
        .BUSY   (BUSY)
    );

    assign CMP = (CB > target);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        n_checks++; if (SAMPLE !== 1'b0) begin n_fail++; $display("FAIL reset_sample got %b exp 0", SAMPLE); end
        n_checks++; if (CB !== 6'd0)     begin n_fail++; $display("FAIL reset_cb got %0d exp 0", CB); end
        n_checks++; if (DOUT !== 6'd0)   begin n_fail++; $display("FAIL reset_dout got %0d exp 0", DOUT); end
        n_checks++; if (DONE !== 1'b0)   begin n_fail++; $display("FAIL reset_done got %b exp 0", DONE); end
        n_checks++; if (BUSY !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    endtask

    // One full conversion, checked edge by edge; optionally pokes START mid-conversion.
    task automatic check_conversion(input logic [NB-1:0] tgt, input bit poke);
        logic [NB-1:0] trials [NB];
        logic [NB-1:0] res;
        logic [NB-1:0] trial;
        logic [NB-1:0] exp_cb;
        logic [NB-1:0] exp_dout;
        logic          exp_s;
        logic          exp_b;
        logic          exp_d;
        res = '0;
        for (int b = NB - 1; b >= 0; b--) begin
            trial = res | (6'd1 << b);
            trials[NB - 1 - b] = trial;
            if (!(trial > tgt)) res = trial;
        end
        target = tgt;
        START  = 1'b1;
        for (int e = 0; e <= SC + NB + 1; e++) begin
            @(posedge CLK);
            #1;
            if (e == 0) START = 1'b0;
            if (poke && e == SC + 3) START = 1'b1;
            if (poke && e == SC + 4) START = 1'b0;
            exp_s = (e < SC);
            exp_b = (e < SC + NB);
            exp_d = (e == SC + NB);
            if (e < SC)           exp_cb = '0;
            else if (e < SC + NB) exp_cb = trials[e - SC];
            else                  exp_cb = res;
            exp_dout = (e >= SC + NB) ? tgt : model_dout;
            n_checks++; if (SAMPLE !== exp_s) begin n_fail++; $display("FAIL conv_sample tgt %0d edge %0d got %b exp %b", tgt, e, SAMPLE, exp_s); end
            n_checks++; if (BUSY !== exp_b)   begin n_fail++; $display("FAIL conv_busy tgt %0d edge %0d got %b exp %b", tgt, e, BUSY, exp_b); end
            n_checks++; if (DONE !== exp_d)   begin n_fail++; $display("FAIL conv_done tgt %0d edge %0d got %b exp %b", tgt, e, DONE, exp_d); end
            n_checks++; if (CB !== exp_cb)    begin n_fail++; $display("FAIL conv_cb tgt %0d edge %0d got %0d exp %0d", tgt, e, CB, exp_cb); end
            n_checks++; if (DOUT !== exp_dout) begin n_fail++; $display("FAIL conv_dout tgt %0d edge %0d got %0d exp %0d", tgt, e, DOUT, exp_dout); end
        end
        model_dout = tgt;
    endtask

    task automatic test_random(input int count);
        for (int i = 0; i < count; i++) begin
            check_conversion(NB'($urandom_range(0, 63)), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int            done_edge [2];
        logic [NB-1:0] done_val [2];
        int            nd;
        nd = 0;
        done_edge[0] = -1; done_edge[1] = -1;
        done_val[0]  = '0; done_val[1]  = '0;
        target = 6'd21;
        START  = 1'b1;
        for (int e = 0; e < 40 && nd < 2; e++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                done_edge[nd] = e;
                done_val[nd]  = DOUT;
                nd++;
                if (nd == 1) target = 6'd42;
                else         START  = 1'b0;
            end
        end
        START = 1'b0;
        n_checks++; if (nd !== 2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", nd); end
        n_checks++; if (done_edge[0] !== SC + NB) begin n_fail++; $display("FAIL b2b_first_edge got %0d exp %0d", done_edge[0], SC + NB); end
        n_checks++; if (done_edge[1] - done_edge[0] !== SC + NB + 1) begin n_fail++; $display("FAIL b2b_gap got %0d exp %0d", done_edge[1] - done_edge[0], SC + NB + 1); end
        n_checks++; if (done_val[0] !== 6'd21) begin n_fail++; $display("FAIL b2b_dout0 got %0d exp 21", done_val[0]); end
        n_checks++; if (done_val[1] !== 6'd42) begin n_fail++; $display("FAIL b2b_dout1 got %0d exp 42", done_val[1]); end
        for (int i = 0; i < 20 && BUSY; i++) begin
            @(posedge CLK);
            #1;
        end
        @(posedge CLK);
        #1;
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got %b exp 0", BUSY); end
        model_dout = 6'd42;
    endtask

    task automatic test_reset_mid_conv();
        target = 6'd45;
        START  = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (SC + 3) @(posedge CLK);
        #1;
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before got %b exp 1", BUSY); end
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++; if (CB !== 6'd0)     begin n_fail++; $display("FAIL abort_cb got %0d exp 0", CB); end
        n_checks++; if (DOUT !== 6'd0)   begin n_fail++; $display("FAIL abort_dout got %0d exp 0", DOUT); end
        n_checks++; if (SAMPLE !== 1'b0) begin n_fail++; $display("FAIL abort_sample got %b exp 0", SAMPLE); end
        n_checks++; if (BUSY !== 1'b0)   begin n_fail++; $display("FAIL abort_busy got %b exp 0", BUSY); end
        n_checks++; if (DONE !== 1'b0)   begin n_fail++; $display("FAIL abort_done got %b exp 0", DONE); end
        @(negedge CLK);
        RST_N = 1'b1;
        model_dout = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            n_checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_quiet cycle %0d got done %b busy %b exp 0 0", i, DONE, BUSY); end
        end
        check_conversion(6'd10, 1'b0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        RST_N      = 1'b0;
        START      = 1'b0;
        target     = '0;
        model_dout = '0;
        test_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        check_conversion(6'd37, 1'b0);
        check_conversion(6'd0, 1'b0);
        check_conversion(6'd63, 1'b0);
        check_conversion(6'd25, 1'b1);
        test_random(12);
        test_back_to_back();
        test_reset_mid_conv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_ctrl_6b.md
SAR_CTRL_6B -- requirements
Module: sar_ctrl_6b

Interface
REQ-001 SHALL provide parameter NBIT, default 6, which sets the DAC code width and drives the 6-bit binary-weighted CDAC bottom-plate bus.
REQ-002 SHALL provide parameter SAMPLE_CYCLES, default 2, which sets the number of clock cycles the SAMPLE output is held high (legal range 1..15).
REQ-003 SHALL provide port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL provide port START, input, 1 bit: conversion request, level-sampled on the rising edge.
REQ-006 SHALL provide port CMP, input, 1 bit: comparator decision on the CDAC top plate CT; 1 means the trial code is too high.
REQ-007 SHALL provide port SAMPLE, output, 1 bit: top-plate sampling switch enable.
REQ-008 SHALL provide port CB, output, NBIT bits: CDAC bottom-plate code; bit i carries weight 2^i.
REQ-009 SHALL provide port DOUT, output, NBIT bits: last completed conversion result.
REQ-010 SHALL provide port DONE, output, 1 bit: one-cycle pulse when DOUT updates.
REQ-011 SHALL provide port BUSY, output, 1 bit: high while a conversion is in progress.
REQ-012 SHALL use one clock with an asynchronous, active-low reset; these are fixed.

Function
REQ-013 SHALL implement the states IDLE, SAMP and CONV, with every output registered.
REQ-014 IDLE: START=1 at an edge -> SAMP, SAMPLE=1, BUSY=1, CB=0, sample counter loaded with SAMPLE_CYCLES-1.
REQ-015 SAMP: counter decrements each edge; at the edge where the counter is 0 -> CONV, SAMPLE=0, CB = MSB only (100000 for NBIT=6), bit index = NBIT-1.
REQ-016 CONV, per edge: if CMP=1, clear CB[index]; if index>0, set CB[index-1] and decrement index.
REQ-017 CONV, at the edge resolving index 0: DOUT <= resolved code, DONE=1 for exactly one cycle, BUSY=0, state -> IDLE.
REQ-018 Latency: if START is captured at edge 0, SAMPLE is high after edges 0..SAMPLE_CYCLES-1 and DONE is high after edge SAMPLE_CYCLES+NBIT (8 for the defaults).
REQ-019 CB SHALL hold the final code in IDLE until the next SAMP entry, which forces CB to 0.
REQ-020 START SHALL be ignored while BUSY=1; there is no queuing.
REQ-021 START held high continuously SHALL start a new conversion at the first edge after DONE (back-to-back, one idle cycle).
REQ-022 CMP SHALL be ignored in IDLE and SAMP.
REQ-023 DOUT SHALL change only on the DONE edge and hold otherwise.

Reset
REQ-024 RST_N=0 SHALL immediately and asynchronously force state=IDLE, SAMPLE=0, CB=0, DOUT=0, DONE=0, BUSY=0 and counter/index=0.
REQ-025 Reset deassertion mid-operation SHALL leave the block in IDLE; a conversion aborted by reset produces no DONE and no DOUT update.
REQ-026 The first START is accepted at the first rising edge after RST_N rises.

Verification (NBIT=6, SAMPLE_CYCLES=2; comparator model CMP = (CB > target))
REQ-027 Target 37, one-cycle START -> CB trial sequence 32, 48->32, 40->32, 36, 38->36, 37; DOUT=37; DONE high one cycle 8 edges after the START edge; SAMPLE high exactly 2 cycles.
REQ-028 Target 0 -> DOUT=0, and target 63 -> DOUT=63; CB equals DOUT in IDLE afterwards.
REQ-029 START pulsed in the 4th CONV cycle -> ignored; exactly one DONE; BUSY profile unchanged.
REQ-030 START held high, targets 21 then 42 -> two DONE pulses 9 edges apart; DOUT=21 then 42.
REQ-031 RST_N low during CONV (after the 3rd decision) -> CB, DOUT, SAMPLE, BUSY at 0 asynchronously; no DONE; a following START with target 10 -> DOUT=10.
